// File: rtl/counter_pkg.sv
// Shared constants and FSM encoding for the parameterised up/down counter.
package counter_pkg;

  localparam int unsigned      DEFAULT_WIDTH   = 4;
  localparam longint unsigned  DEFAULT_MODULUS = 16;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

endpackage

// File: rtl/dff_bank.sv
// WIDTH-bit D register with synchronous reset, providing the true and
// complemented count as separately registered outputs.
module dff_bank
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_nq
);

  // Declaration values give a defined count before the first reset.
  logic [WIDTH-1:0] r_q  = '0;
  logic [WIDTH-1:0] r_nq = '1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q  <= '0;
      r_nq <= '1;
    end else begin
      r_q  <= i_d;
      r_nq <= ~i_d;
    end
  end

  assign o_q  = r_q;
  assign o_nq = r_nq;

endmodule

// File: rtl/param_counter.sv
// Modulo-N up/down counter with saturating parallel load and an optional
// one-shot mode that halts at terminal count until reloaded or reset.
module param_counter
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH    = DEFAULT_WIDTH,
  parameter longint unsigned MODULUS  = DEFAULT_MODULUS,
  parameter bit              ONE_SHOT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] NQ,
  output logic             tc,
  output logic             done
);

  // Terminal value computed in 64 bits then truncated, so MODULUS = 2^WIDTH
  // yields all ones without overflowing a WIDTH-bit comparator.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

  state_t           r_state = ST_RUN;
  logic             r_done  = 1'b0;

  logic             w_atMax;
  logic             w_atZero;
  logic             w_halted;
  logic             w_stopAtTc;
  logic [WIDTH-1:0] w_loadSat;
  logic [WIDTH-1:0] w_countNext;
  logic [WIDTH-1:0] w_qNext;

  always_comb begin
    w_atMax     = (Q == MAX_VAL);
    w_atZero    = (Q == '0);
    tc          = en & ((up_dn & w_atMax) | (~up_dn & w_atZero));
    w_loadSat   = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    w_countNext = up_dn ? (w_atMax  ? '0      : Q + WIDTH'(1))
                        : (w_atZero ? MAX_VAL : Q - WIDTH'(1));
    w_halted    = ONE_SHOT && (r_state == ST_HALT);
    w_stopAtTc  = ONE_SHOT && tc;

    w_qNext = Q;
    if (load) begin
      w_qNext = w_loadSat;
    end else if (en && !w_halted && !w_stopAtTc) begin
      w_qNext = w_countNext;
    end
  end

  dff_bank #(
    .WIDTH (WIDTH)
  ) u_bank (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (w_qNext),
    .o_q   (Q),
    .o_nq  (NQ)
  );

  // One-shot FSM: an enabled terminal count parks in HALT; load or reset resumes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_done  <= 1'b0;
    end else if (load) begin
      r_state <= ST_RUN;
      r_done  <= 1'b0;
    end else if (ONE_SHOT && (r_state == ST_RUN) && tc) begin
      r_state <= ST_HALT;
      r_done  <= 1'b1;
    end
  end

  assign done = ONE_SHOT ? r_done : 1'b0;

endmodule

// File: tb/tb_param_counter.sv
// Bench for param_counter: three configurations driven by shared directed and
// random stimulus, compared against an arithmetic modulo/one-shot model.
module tb_param_counter;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, load;
  logic [3:0] lvA;
  logic [7:0] lvC;
  logic [3:0] qA, nqA, qB, nqB;
  logic [7:0] qC, nqC;
  logic       tcA, tcB, tcC, doneA, doneB, doneC;

  int total = 0;
  int bad   = 0;

  int modV[3]     = '{10, 10, 256};
  bit oneShotV[3] = '{1'b0, 1'b1, 1'b0};
  int qM[3];
  bit haltM[3];

  always #5 clk = ~clk;

  param_counter #(.WIDTH(4), .MODULUS(10), .ONE_SHOT(1'b0)) dutA (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(lvA),
    .Q(qA), .NQ(nqA), .tc(tcA), .done(doneA)
  );

  param_counter #(.WIDTH(4), .MODULUS(10), .ONE_SHOT(1'b1)) dutB (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(lvA),
    .Q(qB), .NQ(nqB), .tc(tcB), .done(doneB)
  );

  param_counter #(.WIDTH(8), .MODULUS(256), .ONE_SHOT(1'b0)) dutC (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(lvC),
    .Q(qC), .NQ(nqC), .tc(tcC), .done(doneC)
  );

  task automatic checkValue(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit modelTc(input int i, input bit e, input bit u);
    return e && ((u && qM[i] == modV[i] - 1) || (!u && qM[i] == 0));
  endfunction

  task automatic checkOutput();
    checkValue("qA", qA, qM[0]);
    checkValue("nqA", nqA, 15 - qM[0]);
    checkValue("doneA", doneA, 0);
    checkValue("qB", qB, qM[1]);
    checkValue("nqB", nqB, 15 - qM[1]);
    checkValue("doneB", doneB, haltM[1]);
    checkValue("qC", qC, qM[2]);
    checkValue("nqC", nqC, 255 - qM[2]);
    checkValue("doneC", doneC, 0);
  endtask

  // Drive one cycle of inputs, check tc before the edge, then the registered state after it.
  task automatic applyStimulus(input bit r, input bit e, input bit u, input bit l,
                               input int valA, input int valC);
    bit tcExp[3];
    int lv;
    @(negedge clk);
    rst   = r;
    en    = e;
    up_dn = u;
    load  = l;
    lvA   = valA[3:0];
    lvC   = valC[7:0];
    for (int i = 0; i < 3; i++) tcExp[i] = modelTc(i, e, u);
    #1;
    checkValue("tcA", tcA, tcExp[0]);
    checkValue("tcB", tcB, tcExp[1]);
    checkValue("tcC", tcC, tcExp[2]);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      lv = (i == 2) ? int'(lvC) : int'(lvA);
      if (r) begin
        qM[i]    = 0;
        haltM[i] = 1'b0;
      end else if (l) begin
        qM[i]    = (lv > modV[i] - 1) ? modV[i] - 1 : lv;
        haltM[i] = 1'b0;
      end else if (e && !haltM[i]) begin
        if (oneShotV[i] && tcExp[i]) haltM[i] = 1'b1;
        else qM[i] = u ? (qM[i] + 1) % modV[i] : (qM[i] + modV[i] - 1) % modV[i];
      end
    end
    #1;
    checkOutput();
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; lvA = '0; lvC = '0;
    for (int i = 0; i < 3; i++) begin
      qM[i]    = 0;
      haltM[i] = 1'b0;
    end
    $display("[TB] start");
    #1;
    checkOutput();

    applyStimulus(1, 0, 1, 0, 0, 0);
    repeat (12) applyStimulus(0, 1, 1, 0, 0, 0);
    checkValue("mod10_up12_qA", qA, 2);
    checkValue("oneshot_stop_qB", qB, 9);
    checkValue("oneshot_done", doneB, 1);
    applyStimulus(0, 1, 1, 0, 0, 0);
    checkValue("halt_ignores_en", qB, 9);

    applyStimulus(0, 0, 1, 1, 3, 3);
    checkValue("oneshot_reload_q", qB, 3);
    checkValue("oneshot_reload_done", doneB, 0);

    applyStimulus(1, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkValue("down_wrap_qA", qA, 9);
    checkValue("down_wrap_qC", qC, 255);

    applyStimulus(0, 1, 1, 1, 7, 7);
    checkValue("load_beats_en", qA, 7);
    applyStimulus(0, 1, 1, 1, 12, 12);
    checkValue("load_sat_qA", qA, 9);
    checkValue("load_wide_qC", qC, 12);

    applyStimulus(0, 0, 1, 1, 5, 5);
    applyStimulus(1, 1, 1, 1, 9, 9);
    checkValue("rst_over_load_q", qA, 0);
    checkValue("rst_over_load_nq", nqA, 15);

    repeat (11) applyStimulus(0, 1, 1, 0, 0, 0);
    checkValue("halt_before_rst", doneB, 1);
    applyStimulus(1, 0, 1, 0, 0, 0);
    checkValue("rst_in_halt_done", doneB, 0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    checkValue("run_after_rst", qB, 1);

    applyStimulus(0, 0, 1, 1, 15, 255);
    applyStimulus(0, 1, 1, 0, 0, 0);
    checkValue("full_range_wrap_qC", qC, 0);

    for (int n = 0; n < 300; n++) begin
      applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 15), $urandom_range(0, 255));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
